// File: rtl/if_id_buffer.sv
// if_id_buffer
//   FIFO between instruction fetch and instruction decode. Fetch pushes
//   {pc, instruction} pairs and decode pops them in order. A branch flush
//   discards every queued wrong-path pair in a single cycle. in_ready is
//   the inverse of the fetch-stage freeze.
//
// Parameters
//   BIT_NUMBER  width of pc and instruction words
//   DEPTH       number of entries (power of two, >= 2)
//   CNT_W       width of the occupancy count
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   flush            branch taken: drop all entries and the pair on the input
//   in_valid         fetch presents a valid pair
//   in_pc            pc of the fetched instruction
//   in_instruction   fetched instruction word
//   in_ready         buffer can accept a pair this cycle
//   out_ready        decode accepts the head pair this cycle
//   out_valid        head pair is valid
//   out_pc           head pc (0 when no valid pair)
//   out_instruction  head instruction (0 when no valid pair, i.e. a NOP)
//   count            current occupancy, 0..DEPTH
//
// Optional feature
//   IF_ID_BUFFER_BYPASS_EN: when the buffer is empty, the incoming pair is
//   presented on out_* in the same cycle. If decode takes it, it is never
//   written. Otherwise it is pushed as usual.

module if_id_buffer #(
  parameter int unsigned BIT_NUMBER = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [BIT_NUMBER-1:0] in_pc,
  input  logic [BIT_NUMBER-1:0] in_instruction,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [BIT_NUMBER-1:0] out_pc,
  output logic [BIT_NUMBER-1:0] out_instruction,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BIT_NUMBER-1:0] pc_mem    [DEPTH];
  logic [BIT_NUMBER-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic stored_valid;
  logic bypass_take;
  logic push;
  logic pop;

  assign count        = count_q;
  assign stored_valid = (count_q != '0);

  // A full buffer refuses input even when decode pops in the same cycle, so
  // in_ready never depends on out_ready.
  assign in_ready = (count_q != FULL_CNT);

`ifdef IF_ID_BUFFER_BYPASS_EN
  logic bypass_valid;

  assign bypass_valid = ~stored_valid & in_valid & ~flush;
  assign bypass_take  = bypass_valid & out_ready;
  assign out_valid    = stored_valid | bypass_valid;

  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    if (stored_valid) begin
      out_pc          = pc_mem[rd_ptr];
      out_instruction = instr_mem[rd_ptr];
    end else if (bypass_valid) begin
      out_pc          = in_pc;
      out_instruction = in_instruction;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign out_valid   = stored_valid;

  // With nothing stored, decode sees an all-zero pair (a NOP bubble).
  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    if (stored_valid) begin
      out_pc          = pc_mem[rd_ptr];
      out_instruction = instr_mem[rd_ptr];
    end
  end
`endif

  // A pair consumed through the bypass path is never written.
  assign push = in_valid & in_ready & ~bypass_take;
  assign pop  = stored_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instruction;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam int unsigned BW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef IF_ID_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [BW-1:0]    in_pc;
  logic [BW-1:0]    in_instruction;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [BW-1:0]    out_pc;
  logic [BW-1:0]    out_instruction;
  logic [CNT_W-1:0] count;

  if_id_buffer #(
    .BIT_NUMBER(BW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instruction (in_instruction),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instruction(out_instruction),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model: an ordered queue of {pc, instruction}.
  logic [2*BW-1:0] mq[$];
  logic            exp_valid;
  logic            exp_ready;
  logic [BW-1:0]   exp_pc;
  logic [BW-1:0]   exp_instr;
  int              exp_count;

  task automatic model_expect();
    exp_count = mq.size();
    exp_ready = (mq.size() != DEPTH);
    if (mq.size() != 0) begin
      exp_valid = 1'b1;
      exp_pc    = mq[0][2*BW-1:BW];
      exp_instr = mq[0][BW-1:0];
    end else if (BYPASS && in_valid && !flush) begin
      exp_valid = 1'b1;
      exp_pc    = in_pc;
      exp_instr = in_instruction;
    end else begin
      exp_valid = 1'b0;
      exp_pc    = '0;
      exp_instr = '0;
    end
  endtask

  task automatic model_update();
    bit take_direct;
    bit do_pop;
    bit do_push;
    if (rst || flush) begin
      mq.delete();
    end else begin
      take_direct = BYPASS && mq.size() == 0 && in_valid && out_ready;
      do_pop      = mq.size() != 0 && out_ready;
      do_push     = in_valid && mq.size() != DEPTH && !take_direct;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_instruction});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [BW-1:0] pc, input logic [BW-1:0] ins,
                       input logic ordy, input logic fl);
    rst            = 1'b0;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = ordy;
    flush          = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== '0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_instruction !== '0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instruction); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BW'(4 * (i + 1)), $urandom, 1'b0, 1'b0);
      tick();
    end
    // reset wins over concurrent push, pop and flush
    drive(1'b1, 32'h0000_0099, $urandom, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== '0) begin n_fail++; $display("FAIL midreset_out_pc: got %h want 0", out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_in_order_drain();
    logic [BW-1:0] pcs [3];
    logic [BW-1:0] ins [3];
    pcs = '{32'd4, 32'd8, 32'd12};
    ins = '{32'hE3A0_0001, 32'hE3A0_1002, 32'hE080_2001};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ins[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (out_pc !== pcs[i]) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, pcs[i]); end
      n_cmp++; if (out_instruction !== ins[i]) begin n_fail++; $display("FAIL drain_instr[%0d]: got %h want %h", i, out_instruction, ins[i]); end
      n_cmp++; if (count !== CNT_W'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 3 - i); end
      tick();
    end
    #1;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL drain_final_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_final_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    drive(1'b1, 32'hDEAD_BEE0, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    model_expect();
    n_cmp++; if (count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_no_capture_count: got %0d want %0d", count, DEPTH); end
    n_cmp++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL full_head_pc: got %h want %h", out_pc, exp_pc); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (count !== CNT_W'(DEPTH - 1)) begin n_fail++; $display("FAIL full_pop_count: got %0d want %0d", count, DEPTH - 1); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      #1;
      model_expect();
      n_cmp++; if (out_pc !== exp_pc || out_instruction !== exp_instr) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h/%h want %h/%h", i, out_pc, out_instruction, exp_pc, exp_instr);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      #1;
      model_expect();
      n_cmp++; if (count !== CNT_W'(2)) begin n_fail++; $display("FAIL simul_count[%0d]: got %0d want 2", i, count); end
      n_cmp++; if (out_pc !== exp_pc || out_instruction !== exp_instr) begin
        n_fail++; $display("FAIL simul_head[%0d]: got %h/%h want %h/%h", i, out_pc, out_instruction, exp_pc, exp_instr);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      model_expect();
      n_cmp++; if (out_pc !== exp_pc || out_instruction !== exp_instr) begin
        n_fail++; $display("FAIL simul_drain[%0d]: got %h/%h want %h/%h", i, out_pc, out_instruction, exp_pc, exp_instr);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BW'(4 * (i + 1)), $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h0000_0040, $urandom, 1'b1, 1'b1);
    #1;
    n_cmp++; if (out_pc !== 32'd4) begin n_fail++; $display("FAIL flush_cycle_pc: got %h want 4", out_pc); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== '0) begin n_fail++; $display("FAIL flush_pc: got %h want 0", out_pc); end
    drive(1'b1, 32'h0000_0100, 32'hE1A0_0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_refill_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_refill_pc: got %h want 100", out_pc); end
    n_cmp++; if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL flush_refill_count: got %0d want 1", count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
      #1;
      model_expect();
      n_cmp++;
      if ({out_valid, out_pc, out_instruction, in_ready, count} !==
          {exp_valid, exp_pc, exp_instr, exp_ready, CNT_W'(exp_count)}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b pc=%h ins=%h rdy=%b cnt=%0d want v=%b pc=%h ins=%h rdy=%b cnt=%0d",
                 i, out_valid, out_pc, out_instruction, in_ready, count,
                 exp_valid, exp_pc, exp_instr, exp_ready, exp_count);
      end
      tick();
    end
  endtask

`ifdef IF_ID_BUFFER_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    drive(1'b1, 32'h0000_0020, 32'hE3A0_0005, 1'b1, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0000_0020) begin n_fail++; $display("FAIL bypass_pc: got %h want 20", out_pc); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_after_valid: got %b want 0", out_valid); end
    drive(1'b1, 32'h0000_0024, 32'hE3A0_0006, 1'b0, 1'b0);
    #1;
    n_cmp++; if (out_pc !== 32'h0000_0024) begin n_fail++; $display("FAIL bypass_stall_pc: got %h want 24", out_pc); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL bypass_stall_count: got %0d want 1", count); end
    n_cmp++; if (out_pc !== 32'h0000_0024) begin n_fail++; $display("FAIL bypass_stall_head: got %h want 24", out_pc); end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst            = 1'b1;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_instruction = '0;
    out_ready      = 1'b0;
    test_reset();
    test_in_order_drain();
    test_full_stall();
    test_simultaneous();
    test_flush();
`ifdef IF_ID_BUFFER_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Small FIFO between the instruction-fetch stage and the instruction-decode stage.
- Decouples fetch from decode stalls by queuing {pc, instruction} pairs produced by fetch.
- The decode side consumes pairs in order.
- Branch flush discards all queued wrong-path instructions in one cycle.
- in_ready drives the fetch-stage freeze (freeze = ~in_ready).

Parameters:
- BIT_NUMBER, 32: width of pc and instruction words.
- DEPTH, 4: number of entries. Must be a power of two and ≥2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  branch taken; discard all entries.
- in_valid  input  1  fetch presents a valid pair.
- in_pc  input  BIT_NUMBER  pc of the fetched instruction (already +4).
- in_instruction  input  BIT_NUMBER  fetched instruction word.
- in_ready  output  1  buffer can accept a pair this cycle.
- out_ready  input  1  decode accepts the head pair this cycle.
- out_valid  output  1  head pair is valid.
- out_pc  output  BIT_NUMBER  head pc.
- out_instruction  output  BIT_NUMBER  head instruction.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each {pc, instruction}.
  - Read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
  - Occupancy register count.
- Reset (rst=1 at edge): rd_ptr=0, wr_ptr=0, count=0. Array contents need not be cleared.
  - Outputs after reset: out_valid=0, out_pc=0, out_instruction=0, in_ready=1.
  - Reset overrides flush, push and pop.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_pc / out_instruction = entry[rd_ptr] when out_valid, otherwise forced to 0 (a NOP bubble to decode).
- Push: push = in_valid & in_ready. Writes entry[wr_ptr]; wr_ptr+1.
- Pop: pop = out_valid & out_ready. Advances rd_ptr+1.
- Simultaneous push and pop: both pointers advance; count unchanged.
- Count update: count += push - pop.
- Full: in_ready=0, so no push even if a pop occurs in the same cycle. This is deliberately conservative to keep in_ready free of any out_ready path.
- Empty: no pop; out_ready is ignored.
- Flush (flush=1, rst=0):
  - Next state: rd_ptr=wr_ptr=0, count=0.
  - A concurrent push or pop is discarded.
  - The pair presented by fetch in the flush cycle is wrong-path and is dropped.
- Latency: a pair pushed at edge N is visible on out_* from edge N onward (one cycle push-to-visible). FIFO order is preserved.
- in_valid while in_ready=0: fetch must hold its data. The buffer does not capture it.

Optional Feature:
- Macro: IF_ID_BUFFER_BYPASS_EN.
- When defined:
  - If count==0 and in_valid=1 (and flush=0), out_valid=1 combinationally, with out_pc/out_instruction = in_pc/in_instruction.
  - If out_ready=1 in that cycle, the pair is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the pair is pushed normally.
  - Zero-cycle latency when empty.
- When not defined: behaviour exactly as above; the empty-buffer path has one-cycle latency and there is no in→out combinational path.

Test Plan:
- Reset mid-stream: push 3 pairs, then assert rst for 1 cycle → count=0, out_valid=0, out_pc=0, in_ready=1 on the next cycle.
- In-order drain: push (pc=4,instr=0xE3A00001), (8,0xE3A01002), (12,0xE0802001) with out_ready=0, then out_ready=1 → out_pc sequence 4, 8, 12 on consecutive cycles; count 3→2→1→0.
- Full stall: push 4 pairs with out_ready=0 → count=4, in_ready=0. A 5th in_valid is not captured. Pop one → in_ready=1 the next cycle.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, pointers wrap past DEPTH-1 and data order is preserved.
- Flush with concurrent push at count=3: flush=1, in_valid=1 (pc=0x40) → next cycle count=0, out_valid=0. pc=0x40 never appears on out_pc. A later push of pc=0x100 appears as the head.
- Bypass (macro defined): empty buffer, in_valid=1, pc=0x20, out_ready=1 → same cycle out_valid=1, out_pc=0x20; next cycle count=0.
